// File: rtl/pong_pkg.sv
// Screen/object geometry, game state encoding and small helpers shared by the
// pong game controller and its paddle mover.
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_XL    = 16;
  localparam int PADDLE_XR    = 616;
  localparam int PADDLE_STEP  = 4;
  localparam int BALL_STEP    = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int SCORE_MAX    = 9;

  // Centre / home positions
  localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);  // 316
  localparam logic [9:0] BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);  // 236
  localparam logic [9:0] PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);   // 208

  // Signed 11-bit views used by the ball arithmetic (underflow shows as < 0)
  localparam logic signed [10:0] S_BALL_STEP = 11'(BALL_STEP);
  localparam logic signed [10:0] S_BALL_SIZE = 11'(BALL_SIZE);
  localparam logic signed [10:0] S_PADDLE_H  = 11'(PADDLE_H);
  localparam logic signed [10:0] Y_WALL      = 11'(V_ACTIVE - BALL_SIZE);  // 472
  localparam logic signed [10:0] X_MISS_R    = 11'(H_ACTIVE - BALL_SIZE);  // 632
  localparam logic signed [10:0] XL_EDGE     = 11'(PADDLE_XL);             // 16
  localparam logic signed [10:0] XL_FACE     = 11'(PADDLE_XL + PADDLE_W);  // 24
  localparam logic signed [10:0] XR_EDGE     = 11'(PADDLE_XR);             // 616
  localparam logic signed [10:0] XR_FACE     = 11'(PADDLE_XR - BALL_SIZE); // 608

  localparam logic [3:0] SCORE_TOP  = 4'(SCORE_MAX);
  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_PADDLE, SQ_BALL, SQ_COLLIDE, SQ_COMMIT
  } seq_e;

  // Score increment that sticks at SCORE_MAX
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_TOP) ? SCORE_TOP : s + 4'd1;
  endfunction

  // Vertical overlap of the ball (top y = by) with a paddle (top y = py)
  function automatic logic y_overlap(input logic signed [10:0] by, input logic [9:0] py);
    logic signed [10:0] sp;
    sp = $signed({1'b0, py});
    return (by + S_BALL_SIZE > sp) && (by < sp + S_PADDLE_H);
  endfunction

endpackage

// File: rtl/pong_paddle_mover.sv
// One paddle step: up/down request applied to the current top y, clamped to
// the visible column. Simultaneous up and down cancel out.
module pong_paddle_mover
  import pong_pkg::*;
(
  input  logic       up,
  input  logic       dn,
  input  logic [9:0] cur_y,
  output logic [9:0] next_y
);

  localparam logic signed [10:0] STEP  = 11'(PADDLE_STEP);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - PADDLE_H);

  logic signed [10:0] y_up, y_dn;

  assign y_up = $signed({1'b0, cur_y}) - STEP;
  assign y_dn = $signed({1'b0, cur_y}) + STEP;

  // Pick the moved position, saturating at the top and bottom limits
  always_comb begin
    next_y = cur_y;
    if (up && !dn)
      next_y = (y_up < 11'sd0) ? 10'd0 : y_up[9:0];
    else if (dn && !up)
      next_y = (y_dn > Y_MAX) ? Y_MAX[9:0] : y_dn[9:0];
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer. Each accepted frame tick runs PADDLE, BALL,
// COLLIDE and COMMIT on consecutive cycles; every visible output is written
// only in COMMIT, so the renderer sees one consistent snapshot per frame.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       busy
);

  seq_e        seq_q, seq_d;
  game_state_e st_q, st_d;

  logic       dx_q, dy_q;          // 1 = right / down
  logic [5:0] serve_cnt, cnt_d;
  logic       start_pend;
  logic       moving;

  // Stage results
  logic [9:0]         pl_mv, pr_mv, pl_w, pr_w;
  logic signed [10:0] nx_w, ny_w, cx_w, cy_w;
  logic               cdx_w, cdy_w;

  // Combinational collision result (registered in COLLIDE)
  logic signed [10:0] col_x, col_y;
  logic               col_dx, col_dy;

  // Commit-stage next values
  logic [9:0] bx_d, by_d, pl_d, pr_d;
  logic [3:0] sl_d, sr_d;
  logic       dx_d, dy_d, miss_l, miss_r;

  assign busy       = (seq_q != SQ_IDLE);
  assign game_state = st_q;
  assign moving     = (st_q == ST_SERVE) || (st_q == ST_PLAY);

  pong_paddle_mover u_mover_l (.up(btn_l_up), .dn(btn_l_dn), .cur_y(paddle_l_y), .next_y(pl_mv));
  pong_paddle_mover u_mover_r (.up(btn_r_up), .dn(btn_r_dn), .cur_y(paddle_r_y), .next_y(pr_mv));

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= SQ_IDLE;
    else        seq_q <= seq_d;
  end

  // Sequencer next state: ticks are only accepted while idle
  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      SQ_IDLE:    if (frame_tick) seq_d = SQ_PADDLE;
      SQ_PADDLE:  seq_d = SQ_BALL;
      SQ_BALL:    seq_d = SQ_COLLIDE;
      SQ_COLLIDE: seq_d = SQ_COMMIT;
      SQ_COMMIT:  seq_d = SQ_IDLE;
      default:    seq_d = SQ_IDLE;
    endcase
  end

  // Start request latch, consumed by the next commit whatever the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 start_pend <= 1'b0;
    else if (start)             start_pend <= 1'b1;
    else if (seq_q == SQ_COMMIT) start_pend <= 1'b0;
  end

  // Wall bounce first, then paddle faces checked against the bounced y
  always_comb begin
    col_x  = nx_w;
    col_y  = ny_w;
    col_dx = dx_q;
    col_dy = dy_q;
    if (ny_w <= 11'sd0) begin
      col_y  = 11'sd0;
      col_dy = 1'b1;
    end else if (ny_w >= Y_WALL) begin
      col_y  = Y_WALL;
      col_dy = 1'b0;
    end
    if (!dx_q && nx_w <= XL_FACE && nx_w > XL_EDGE && y_overlap(col_y, pl_w)) begin
      col_x  = XL_FACE;
      col_dx = 1'b1;
    end else if (dx_q && nx_w >= XR_FACE && nx_w < XR_EDGE && y_overlap(col_y, pr_w)) begin
      col_x  = XR_FACE;
      col_dx = 1'b0;
    end
  end

  // Game FSM next state and all commit values; a miss discards the frame's
  // ball motion and re-centres the ball
  always_comb begin
    st_d   = st_q;
    bx_d   = ball_x;
    by_d   = ball_y;
    dx_d   = dx_q;
    dy_d   = dy_q;
    pl_d   = pl_w;
    pr_d   = pr_w;
    sl_d   = score_l;
    sr_d   = score_r;
    cnt_d  = serve_cnt;
    miss_l = (cx_w <= 11'sd0);
    miss_r = (cx_w >= X_MISS_R);
    case (st_q)
      ST_IDLE: if (start_pend) begin
        st_d  = ST_SERVE;
        cnt_d = '0;
        dy_d  = ~dy_q;
      end
      ST_SERVE: begin
        if (serve_cnt == SERVE_LAST) st_d = ST_PLAY;
        else                         cnt_d = serve_cnt + 6'd1;
      end
      ST_PLAY: begin
        if (miss_l || miss_r) begin
          bx_d  = BALL_X0;
          by_d  = BALL_Y0;
          cnt_d = '0;
          if (miss_l) begin
            sr_d = sat_inc(score_r);
            dx_d = 1'b0;           // serve toward the side that conceded
          end else begin
            sl_d = sat_inc(score_l);
            dx_d = 1'b1;
          end
          if (sl_d == SCORE_TOP || sr_d == SCORE_TOP) begin
            st_d = ST_OVER;
          end else begin
            st_d = ST_SERVE;
            dy_d = ~dy_q;
          end
        end else begin
          bx_d = cx_w[9:0];
          by_d = cy_w[9:0];
          dx_d = cdx_w;
          dy_d = cdy_w;
        end
      end
      ST_OVER: if (start_pend) begin
        st_d  = ST_SERVE;
        cnt_d = '0;
        sl_d  = '0;
        sr_d  = '0;
        bx_d  = BALL_X0;
        by_d  = BALL_Y0;
        pl_d  = PADDLE_Y0;
        pr_d  = PADDLE_Y0;
        dx_d  = 1'b1;
        dy_d  = ~dy_q;
      end
      default: ;
    endcase
  end

  // Stage registers and the committed game state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_w       <= PADDLE_Y0;
      pr_w       <= PADDLE_Y0;
      nx_w       <= '0;
      ny_w       <= '0;
      cx_w       <= '0;
      cy_w       <= '0;
      cdx_w      <= 1'b1;
      cdy_w      <= 1'b1;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      paddle_l_y <= PADDLE_Y0;
      paddle_r_y <= PADDLE_Y0;
      score_l    <= '0;
      score_r    <= '0;
      st_q       <= ST_IDLE;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      serve_cnt  <= '0;
    end else begin
      case (seq_q)
        SQ_PADDLE: begin
          pl_w <= moving ? pl_mv : paddle_l_y;
          pr_w <= moving ? pr_mv : paddle_r_y;
        end
        SQ_BALL: begin
          nx_w <= $signed({1'b0, ball_x}) + (dx_q ? S_BALL_STEP : -S_BALL_STEP);
          ny_w <= $signed({1'b0, ball_y}) + (dy_q ? S_BALL_STEP : -S_BALL_STEP);
        end
        SQ_COLLIDE: begin
          cx_w  <= col_x;
          cy_w  <= col_y;
          cdx_w <= col_dx;
          cdy_w <= col_dy;
        end
        SQ_COMMIT: begin
          ball_x     <= bx_d;
          ball_y     <= by_d;
          paddle_l_y <= pl_d;
          paddle_r_y <= pr_d;
          score_l    <= sl_d;
          score_r    <= sr_d;
          st_q       <= st_d;
          dx_q       <= dx_d;
          dy_q       <= dy_d;
          serve_cnt  <= cnt_d;
        end
        default: ;
      endcase
    end
  end

endmodule
